// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the simptel multicycle controller:
// opcodes, ALU functs, datapath mux codes, FSM states.
package multicycle_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [2:0] SRCB_B    = 3'b000;
  localparam logic [2:0] SRCB_4    = 3'b001;
  localparam logic [2:0] SRCB_SIMM = 3'b010;
  localparam logic [2:0] SRCB_ZIMM = 3'b011;
  localparam logic [2:0] SRCB_BOFF = 3'b100;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [2:0] PWC_NONE = 3'b000;
  localparam logic [2:0] PWC_EQ   = 3'b001;
  localparam logic [2:0] PWC_NE   = 3'b010;
  localparam logic [2:0] PWC_GTZ  = 3'b011;
  localparam logic [2:0] PWC_LEZ  = 3'b100;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_EXEC     = 4'd2;
  localparam state_t S_ALU_WB   = 4'd3;
  localparam state_t S_MEM_ADDR = 4'd4;
  localparam state_t S_MEM_RD   = 4'd5;
  localparam state_t S_MEM_WB   = 4'd6;
  localparam state_t S_MEM_WR   = 4'd7;
  localparam state_t S_BRANCH   = 4'd8;
  localparam state_t S_JUMP     = 4'd9;
  localparam state_t S_TRAP     = 4'd10;

  typedef enum logic [2:0] {
    C_ALU_R,
    C_ALU_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_ILLEGAL
  } iclass_t;

  function automatic iclass_t classify(
    input logic [5:0] op
  );
    case (op)
      OP_RTYPE: return C_ALU_R;
      OP_ADDI, OP_ANDI,
      OP_ORI, OP_XORI: return C_ALU_I;
      OP_LW: return C_LOAD;
      OP_SW: return C_STORE;
      OP_BEQ, OP_BNE,
      OP_BLEZ, OP_BGTZ: return C_BRANCH;
      OP_J, OP_JAL: return C_JUMP;
      default: return C_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields in, mux/enable controls out.
// trap exists only with MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
interface multicycle_ctrl_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 6
);
  logic [OPCODE_W-1:0] opCode;
  logic [OPCODE_W-1:0] funct;
  logic [ALUOP_W-1:0]  ALUOp;
  logic                ALUSrcA;
  logic [2:0]          ALUSrcB;
  logic [1:0]          PCSource;
  logic                PCWrite;
  logic [2:0]          PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                RegWrite;
  logic [1:0]          RegDst;
  logic [1:0]          MemtoReg;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic                trap;
`endif

  modport master (
    input  opCode, funct,
    output ALUOp, ALUSrcA, ALUSrcB,
    output PCSource, PCWrite, PCWriteCond,
    output IorD, MemRead, MemWrite, IRWrite,
    output RegWrite, RegDst, MemtoReg
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , output trap
`endif
  );

  modport slave (
    output opCode, funct,
    input  ALUOp, ALUSrcA, ALUSrcB,
    input  PCSource, PCWrite, PCWriteCond,
    input  IorD, MemRead, MemWrite, IRWrite,
    input  RegWrite, RegDst, MemtoReg
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , input trap
`endif
  );
endinterface

// File: rtl/multicycle_ctrl_mem_lat_counter.sv
// Memory latency counter: runs 0..MEM_LAT-1 while an access
// state is active, clears on done or when inactive.
module mem_lat_counter #(
  parameter int MEM_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  output logic o_start,
  output logic o_done
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_active || o_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_start = (r_cnt == '0);
  assign o_done  = (r_cnt == CW'(MEM_LAT - 1));
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the simptel MIPS-subset datapath.
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: unknown opcodes park in TRAP.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 6,
  parameter int MEM_LAT  = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  multicycle_ctrl_if.master ctl
);
  state_t  r_state;
  state_t  w_next;
  iclass_t w_cls;
  logic [5:0] w_op;
  logic w_cnt_active;
  logic w_cnt_start;
  logic w_cnt_done;
  logic w_unused;

  logic [ALUOP_W-1:0] w_aluop;
  logic [ALUOP_W-1:0] w_ex_aluop;
  logic [2:0] w_ex_srcb;
  logic [2:0] w_br_cond;
  logic       w_srca;
  logic [2:0] w_srcb;
  logic [1:0] w_pcsrc;
  logic       w_pcw;
  logic [2:0] w_pcwc;
  logic       w_iord;
  logic       w_mrd;
  logic       w_mwr;
  logic       w_irw;
  logic       w_rw;
  logic [1:0] w_rdst;
  logic [1:0] w_m2r;

  assign w_op  = 6'(ctl.opCode);
  assign w_cls = classify(w_op);
  assign w_unused = w_cnt_start;

  assign w_cnt_active = (r_state == S_FETCH)
                     || (r_state == S_MEM_RD)
                     || (r_state == S_MEM_WR);

  mem_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_active (w_cnt_active),
    .o_start  (w_cnt_start),
    .o_done   (w_cnt_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_cnt_done) w_next = S_DECODE;
      S_DECODE: begin
        case (w_cls)
          C_ALU_R, C_ALU_I:  w_next = S_EXEC;
          C_LOAD, C_STORE:   w_next = S_MEM_ADDR;
          C_BRANCH:          w_next = S_BRANCH;
          C_JUMP:            w_next = S_JUMP;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:           w_next = S_TRAP;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_EXEC:     w_next = S_ALU_WB;
      S_ALU_WB:   w_next = S_FETCH;
      S_MEM_ADDR: w_next = (w_cls == C_LOAD) ?
                           S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (w_cnt_done) w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   if (w_cnt_done) w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  // EXEC operand/op selection, reused unchanged in ALU_WB
  always_comb begin
    w_ex_srcb  = SRCB_ZIMM;
    w_ex_aluop = ALUOP_W'(FN_XOR);
    unique case (1'b1)
      (w_cls == C_ALU_R): begin
        w_ex_srcb  = SRCB_B;
        w_ex_aluop = ALUOP_W'(ctl.funct);
      end
      (w_op == OP_ADDI): begin
        w_ex_srcb  = SRCB_SIMM;
        w_ex_aluop = ALUOP_W'(FN_ADD);
      end
      (w_op == OP_ANDI): w_ex_aluop = ALUOP_W'(FN_AND);
      (w_op == OP_ORI):  w_ex_aluop = ALUOP_W'(FN_OR);
      default: ;
    endcase
  end

  always_comb begin
    case (w_op)
      OP_BEQ:  w_br_cond = PWC_EQ;
      OP_BNE:  w_br_cond = PWC_NE;
      OP_BGTZ: w_br_cond = PWC_GTZ;
      OP_BLEZ: w_br_cond = PWC_LEZ;
      default: w_br_cond = PWC_NONE;
    endcase
  end

  always_comb begin
    w_aluop = '0;
    w_srca  = 1'b0;
    w_srcb  = SRCB_B;
    w_pcsrc = PCS_ALU;
    w_pcw   = 1'b0;
    w_pcwc  = PWC_NONE;
    w_iord  = 1'b0;
    w_mrd   = 1'b0;
    w_mwr   = 1'b0;
    w_irw   = 1'b0;
    w_rw    = 1'b0;
    w_rdst  = RD_RT;
    w_m2r   = M2R_ALU;
    case (r_state)
      S_FETCH: begin
        w_mrd  = 1'b1;
        w_srcb = SRCB_4;
        if (w_cnt_done) begin
          w_irw = 1'b1;
          w_pcw = 1'b1;
        end
      end
      S_DECODE: begin
        w_srcb  = SRCB_BOFF;
        w_aluop = ALUOP_W'(FN_ADD);
      end
      S_EXEC: begin
        w_srca  = 1'b1;
        w_srcb  = w_ex_srcb;
        w_aluop = w_ex_aluop;
      end
      S_ALU_WB: begin
        w_srca  = 1'b1;
        w_srcb  = w_ex_srcb;
        w_aluop = w_ex_aluop;
        w_rw    = 1'b1;
        w_rdst  = (w_cls == C_ALU_R) ? RD_RD : RD_RT;
      end
      S_MEM_ADDR: begin
        w_srca  = 1'b1;
        w_srcb  = SRCB_SIMM;
        w_aluop = ALUOP_W'(FN_ADD);
      end
      S_MEM_RD: begin
        w_iord = 1'b1;
        w_mrd  = 1'b1;
      end
      S_MEM_WB: begin
        w_rw  = 1'b1;
        w_m2r = M2R_MDR;
      end
      S_MEM_WR: begin
        w_iord = 1'b1;
        w_mwr  = 1'b1;
      end
      S_BRANCH: begin
        w_srca  = 1'b1;
        w_srcb  = SRCB_B;
        w_aluop = ALUOP_W'(FN_SUB);
        w_pcsrc = PCS_ALUOUT;
        w_pcwc  = w_br_cond;
      end
      S_JUMP: begin
        w_pcsrc = PCS_JUMP;
        w_pcw   = 1'b1;
        // PC already holds PC+4, i.e. the JAL return address
        if (w_op == OP_JAL) begin
          w_rw   = 1'b1;
          w_rdst = RD_RA;
          w_m2r  = M2R_PC;
        end
      end
      default: ;
    endcase
  end

  assign ctl.ALUOp       = i_rst_n ? w_aluop : '0;
  assign ctl.ALUSrcA     = i_rst_n & w_srca;
  assign ctl.ALUSrcB     = i_rst_n ? w_srcb  : '0;
  assign ctl.PCSource    = i_rst_n ? w_pcsrc : '0;
  assign ctl.PCWrite     = i_rst_n & w_pcw;
  assign ctl.PCWriteCond = i_rst_n ? w_pcwc  : '0;
  assign ctl.IorD        = i_rst_n & w_iord;
  assign ctl.MemRead     = i_rst_n & w_mrd;
  assign ctl.MemWrite    = i_rst_n & w_mwr;
  assign ctl.IRWrite     = i_rst_n & w_irw;
  assign ctl.RegWrite    = i_rst_n & w_rw;
  assign ctl.RegDst      = i_rst_n ? w_rdst : '0;
  assign ctl.MemtoReg    = i_rst_n ? w_m2r  : '0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign ctl.trap        = i_rst_n & (r_state == S_TRAP);
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction
// expected control traces built from the phase rules.
module tb_multicycle_ctrl;
  localparam int L = 3;

  typedef struct packed {
    logic       trap;
    logic [5:0] aluop;
    logic       srca;
    logic [2:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw;
    logic [2:0] pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] m2r;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  ctl_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OPCODE_W(6), .ALUOP_W(6)) bus ();

  multicycle_ctrl #(
    .OPCODE_W (6),
    .ALUOP_W  (6),
    .MEM_LAT  (L)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .ctl     (bus)
  );

  function automatic ctl_t obs();
    ctl_t c;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    c.trap  = bus.trap;
`else
    c.trap  = 1'b0;
`endif
    c.aluop = bus.ALUOp;
    c.srca  = bus.ALUSrcA;
    c.srcb  = bus.ALUSrcB;
    c.pcsrc = bus.PCSource;
    c.pcw   = bus.PCWrite;
    c.pcwc  = bus.PCWriteCond;
    c.iord  = bus.IorD;
    c.mrd   = bus.MemRead;
    c.mwr   = bus.MemWrite;
    c.irw   = bus.IRWrite;
    c.rw    = bus.RegWrite;
    c.rdst  = bus.RegDst;
    c.m2r   = bus.MemtoReg;
    return c;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // Expected per-cycle controls for one instruction
  task automatic build(input logic [5:0] op,
                       input logic [5:0] fn);
    ctl_t c;
    exp_q.delete();
    for (int i = 0; i < L; i++) begin
      c = '0;
      c.mrd = 1'b1;
      c.srcb = 3'b001;
      if (i == L - 1) begin
        c.irw = 1'b1;
        c.pcw = 1'b1;
      end
      exp_q.push_back(c);
    end
    c = '0;
    c.srcb = 3'b100;
    c.aluop = 6'b100000;
    exp_q.push_back(c);
    c = '0;
    case (op)
      6'b000000, 6'b001000, 6'b001100,
      6'b001101, 6'b001110: begin
        c.srca = 1'b1;
        case (op)
          6'b000000: begin c.srcb = 3'b000; c.aluop = fn; end
          6'b001000: begin c.srcb = 3'b010; c.aluop = 6'b100000; end
          6'b001100: begin c.srcb = 3'b011; c.aluop = 6'b100100; end
          6'b001101: begin c.srcb = 3'b011; c.aluop = 6'b100101; end
          default:   begin c.srcb = 3'b011; c.aluop = 6'b100110; end
        endcase
        exp_q.push_back(c);
        c.rw = 1'b1;
        c.rdst = (op == 6'b000000) ? 2'b01 : 2'b00;
        exp_q.push_back(c);
      end
      6'b100011, 6'b101011: begin
        c.srca = 1'b1;
        c.srcb = 3'b010;
        c.aluop = 6'b100000;
        exp_q.push_back(c);
        for (int i = 0; i < L; i++) begin
          c = '0;
          c.iord = 1'b1;
          if (op == 6'b100011) c.mrd = 1'b1;
          else c.mwr = 1'b1;
          exp_q.push_back(c);
        end
        if (op == 6'b100011) begin
          c = '0;
          c.rw = 1'b1;
          c.m2r = 2'b01;
          exp_q.push_back(c);
        end
      end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
        c.srca = 1'b1;
        c.aluop = 6'b100010;
        c.pcsrc = 2'b01;
        case (op)
          6'b000100: c.pcwc = 3'b001;
          6'b000101: c.pcwc = 3'b010;
          6'b000111: c.pcwc = 3'b011;
          default:   c.pcwc = 3'b100;
        endcase
        exp_q.push_back(c);
      end
      6'b000010, 6'b000011: begin
        c.pcsrc = 2'b10;
        c.pcw = 1'b1;
        if (op == 6'b000011) begin
          c.rw = 1'b1;
          c.rdst = 2'b10;
          c.m2r = 2'b10;
        end
        exp_q.push_back(c);
      end
      default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        c.trap = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(c);
`endif
      end
    endcase
  endtask

  // Starts at a negedge with the DUT in the first FETCH cycle
  task automatic run_instr(input string tag,
                           input logic [5:0] op,
                           input logic [5:0] fn);
    bus.opCode = op;
    bus.funct = fn;
    build(op, fn);
    for (int k = 0; k < exp_q.size(); k++) begin
      #1;
      chk($sformatf("%s[%0d]", tag, k),
          32'(obs()), 32'(exp_q[k]));
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 chk({tag, "_now"}, 32'(obs()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 chk({tag, "_hold"}, 32'(obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [5:0] legal [13] = '{
    6'b000000, 6'b001000, 6'b001100, 6'b001101,
    6'b001110, 6'b000100, 6'b000101, 6'b000110,
    6'b000111, 6'b000010, 6'b000011, 6'b100011,
    6'b101011
  };

  initial begin
    bus.opCode = '0;
    bus.funct = '0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("reset", 32'(obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("add",  6'b000000, 6'b100000);
    run_instr("sub",  6'b000000, 6'b100010);
    run_instr("lw",   6'b100011, 6'b000000);
    run_instr("sw",   6'b101011, 6'b010101);
    run_instr("bne",  6'b000101, 6'b000000);
    run_instr("beq",  6'b000100, 6'b000000);
    run_instr("bgtz", 6'b000111, 6'b000000);
    run_instr("blez", 6'b000110, 6'b000000);
    run_instr("j",    6'b000010, 6'b000000);
    run_instr("jal",  6'b000011, 6'b000000);
    run_instr("addi", 6'b001000, 6'b111111);
    run_instr("andi", 6'b001100, 6'b000000);
    run_instr("ori",  6'b001101, 6'b000000);
    run_instr("xori", 6'b001110, 6'b000000);

    for (int n = 0; n < 30; n++) begin
      run_instr($sformatf("rnd%0d", n),
                legal[$urandom_range(0, 12)],
                6'($urandom_range(0, 63)));
    end

    // Reset in the middle of a store access
    bus.opCode = 6'b101011;
    bus.funct = '0;
    build(6'b101011, 6'b000000);
    for (int k = 0; k < L + 3; k++) begin
      #1;
      chk($sformatf("swpre[%0d]", k),
          32'(obs()), 32'(exp_q[k]));
      @(negedge clk);
    end
    #1 chk("midwr_we", 32'(bus.MemWrite), 32'd1);
    do_reset("midwr_rst");
    run_instr("post_rst", 6'b000000, 6'b100100);

    run_instr("illegal", 6'b111111, 6'b000000);
    do_reset("final_rst");
    run_instr("post_ill", 6'b000000, 6'b100101);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
